// File: rtl/edge_frame_writer_pkg.sv
// Shared show-window geometry and writer FSM encoding for the VGA frame path.
// The VGA driver imports the same constants for its display window.
package edge_frame_writer_pkg;

    localparam int SHOW_WIDTH  = 320;
    localparam int SHOW_HEIGHT = 200;
    localparam int FRAME_PIX   = SHOW_WIDTH * SHOW_HEIGHT;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } wr_state_t;

endpackage

// File: rtl/edge_frame_writer.sv
// Writes one raster-order edge frame into the write half of the ping-pong RAM,
// flags completion to the VGA driver and follows its bank swap.
module edge_frame_writer
    import edge_frame_writer_pkg::*;
#(
    parameter int SHOW_WIDTH  = edge_frame_writer_pkg::SHOW_WIDTH,
    parameter int SHOW_HEIGHT = edge_frame_writer_pkg::SHOW_HEIGHT,
    parameter int ADDR_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              din,
    input  logic              din_vld,
    input  logic              din_sop,
    input  logic              din_eop,
    input  logic              rd_end,
    input  logic              rd_addr_sel,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              wr_data,
    output logic              wr_en,
    output logic              wr_sel,
    output logic              wr_end,
    output logic              frm_err,
    output logic              frm_drop
);

    // One spare bit so the counter can sit at FRAME_N even when it equals 2^ADDR_W.
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] FRAME_N = CNT_W'(SHOW_WIDTH * SHOW_HEIGHT);
    localparam logic [CNT_W-1:0] LAST_N  = FRAME_N - 1'b1;

    wr_state_t        state;
    logic [CNT_W-1:0] pix_cnt;

    // The read bank only moves while we sit in DONE, so this never splits a frame.
    assign wr_sel = ~rd_addr_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            pix_cnt  <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= 1'b0;
            wr_end   <= 1'b0;
            frm_err  <= 1'b0;
            frm_drop <= 1'b0;
        end else begin
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= 1'b0;
            frm_err  <= 1'b0;
            frm_drop <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (din_vld && din_sop) begin
                        if (din_eop) begin
                            frm_err <= 1'b1;
                        end else begin
                            wr_en   <= 1'b1;
                            wr_data <= din;
                            pix_cnt <= CNT_W'(1);
                            state   <= ST_WRITE;
                        end
                    end
                end

                ST_WRITE: begin
                    if (din_vld) begin
                        if (din_sop) begin
                            // A new frame aborts the current one and starts over at 0.
                            frm_err <= 1'b1;
                            if (din_eop) begin
                                pix_cnt <= '0;
                                state   <= ST_IDLE;
                            end else begin
                                wr_en   <= 1'b1;
                                wr_data <= din;
                                pix_cnt <= CNT_W'(1);
                            end
                        end else begin
                            if (pix_cnt < FRAME_N) begin
                                wr_en   <= 1'b1;
                                wr_addr <= pix_cnt[ADDR_W-1:0];
                                wr_data <= din;
                            end
                            // Overflow sticks at FRAME_N so a long frame can never wrap back to LAST_N.
                            if (pix_cnt != FRAME_N) begin
                                pix_cnt <= pix_cnt + 1'b1;
                            end
                            if (din_eop) begin
                                pix_cnt <= '0;
                                if (pix_cnt == LAST_N) begin
                                    state <= ST_DONE;
                                end else begin
                                    frm_err <= 1'b1;
                                    state   <= ST_IDLE;
                                end
                            end
                        end
                    end
                end

                ST_DONE: begin
                    if (din_vld && din_sop) begin
                        frm_drop <= 1'b1;
                    end
                    if (rd_end && wr_end) begin
                        wr_end <= 1'b0;
                        state  <= ST_IDLE;
                    end else begin
                        wr_end <= 1'b1;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_edge_frame_writer.sv
// Bench for edge_frame_writer: a reduced-size instance for frame-rule scenarios
// and a full 320x200 instance for one complete frame.
module tb_edge_frame_writer;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int AW = 5;
    localparam int FR = W * H;
    localparam int FULL_PIX = 320 * 200;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, din, din_vld, din_sop, din_eop, rd_end, rd_addr_sel;
    logic [AW-1:0] wr_addr;
    logic wr_data, wr_en, wr_sel, wr_end, frm_err, frm_drop;

    edge_frame_writer #(.SHOW_WIDTH(W), .SHOW_HEIGHT(H), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld), .din_sop(din_sop),
        .din_eop(din_eop), .rd_end(rd_end), .rd_addr_sel(rd_addr_sel),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en), .wr_sel(wr_sel),
        .wr_end(wr_end), .frm_err(frm_err), .frm_drop(frm_drop)
    );

    logic f_din, f_vld, f_sop, f_eop;
    logic [15:0] f_wr_addr;
    logic f_wr_data, f_wr_en, f_wr_sel, f_wr_end, f_frm_err, f_frm_drop;

    edge_frame_writer dut_full (
        .clk(clk), .rst_n(rst_n), .din(f_din), .din_vld(f_vld), .din_sop(f_sop),
        .din_eop(f_eop), .rd_end(1'b0), .rd_addr_sel(1'b0),
        .wr_addr(f_wr_addr), .wr_data(f_wr_data), .wr_en(f_wr_en), .wr_sel(f_wr_sel),
        .wr_end(f_wr_end), .frm_err(f_frm_err), .frm_drop(f_frm_drop)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          data;
    } wr_t;

    typedef struct {
        int nbeats;
        int n_writes;
        int n_err;
        bit done;
    } vec_t;

    wr_t exp_q[$];
    int n_cmp = 0, n_bad = 0;
    int wr_cnt = 0, err_cnt = 0, drop_cnt = 0;
    int f_wr_cnt = 0, f_bad = 0, f_exp_addr = 0, f_err_cnt = 0;
    logic exp_wsel;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard: every write must match the oldest expected write.
    always @(negedge clk) begin
        if (frm_err === 1'b1) err_cnt++;
        if (frm_drop === 1'b1) drop_cnt++;
        if (wr_en === 1'b1) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got addr %0d, expected no write", wr_addr);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", 32'(wr_addr), 32'(e.addr));
                check("wr_data", 32'(wr_data), 32'(e.data));
            end
        end else begin
            check("wr_addr_idle", 32'(wr_addr), 32'd0);
        end
    end

    always @(negedge clk) begin
        if (f_frm_err === 1'b1) f_err_cnt++;
        if (f_wr_en === 1'b1) begin
            if (32'(f_wr_addr) != f_exp_addr || f_wr_data !== (f_wr_addr[0] ^ f_wr_addr[7])) f_bad++;
            f_wr_cnt++;
            f_exp_addr++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic d, input bit sop, input bit eop, input bit exp_wr, input int addr);
        din = d; din_vld = 1'b1; din_sop = sop; din_eop = eop;
        if (exp_wr) exp_q.push_back('{addr: AW'(addr), data: d});
        step();
    endtask

    task automatic idle_cycles(input int n);
        din_vld = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
        repeat (n) step();
    endtask

    task automatic send_frame(input int n, input bit with_eop, input bit can_write);
        for (int i = 0; i < n; i++) begin
            logic d;
            d = 1'($urandom_range(0, 1));
            beat(d, i == 0, with_eop && (i == n - 1),
                 can_write && (i < FR) && !(with_eop && n == 1), i);
        end
    endtask

    task automatic swap(input string tag);
        rd_end = 1'b1;
        step();
        rd_end = 1'b0;
        rd_addr_sel = ~rd_addr_sel;
        exp_wsel = ~exp_wsel;
        #1;
        check({tag, "_wr_end_clr"}, 32'(wr_end), 32'd0);
        check({tag, "_wr_sel"}, 32'(wr_sel), 32'(exp_wsel));
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[6];
        int w0, e0, d0;

        rst_n = 1'b0; din = 1'b0; din_vld = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
        rd_end = 1'b0; rd_addr_sel = 1'b0; exp_wsel = 1'b1;
        f_din = 1'b0; f_vld = 1'b0; f_sop = 1'b0; f_eop = 1'b0;
        repeat (2) step();
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_wr_end", 32'(wr_end), 32'd0);
        check("rst_frm_err", 32'(frm_err), 32'd0);
        check("rst_frm_drop", 32'(frm_drop), 32'd0);
        check("rst_wr_sel", 32'(wr_sel), 32'(exp_wsel));
        rst_n = 1'b1;
        step();

        // Completion and earliest-swap timing around the eop beat.
        send_frame(FR, 1'b1, 1'b1);
        din_vld = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
        rd_end = 1'b1;
        check("eop_t1_wr_en", 32'(wr_en), 32'd1);
        check("eop_t1_wr_addr", 32'(wr_addr), 32'(FR - 1));
        check("eop_t1_wr_end", 32'(wr_end), 32'd0);
        step();
        rd_end = 1'b0;
        check("eop_t2_wr_end", 32'(wr_end), 32'd1);
        swap("first");
        check("first_queue_empty", 32'(exp_q.size()), 32'd0);
        check("first_err", 32'(err_cnt), 32'd0);

        tbl[0] = '{FR,     FR,     0, 1'b1};
        tbl[1] = '{5,      5,      1, 1'b0};
        tbl[2] = '{FR + 3, FR,     1, 1'b0};
        tbl[3] = '{1,      0,      1, 1'b0};
        tbl[4] = '{FR - 1, FR - 1, 1, 1'b0};
        tbl[5] = '{FR + 1, FR,     1, 1'b0};
        for (int k = 0; k < 6; k++) begin
            w0 = wr_cnt; e0 = err_cnt;
            send_frame(tbl[k].nbeats, 1'b1, 1'b1);
            idle_cycles(3);
            check($sformatf("vec%0d_writes", k), 32'(wr_cnt - w0), 32'(tbl[k].n_writes));
            check($sformatf("vec%0d_err", k), 32'(err_cnt - e0), 32'(tbl[k].n_err));
            check($sformatf("vec%0d_wr_end", k), 32'(wr_end), 32'(tbl[k].done));
            check($sformatf("vec%0d_queue", k), 32'(exp_q.size()), 32'd0);
            if (tbl[k].done) swap($sformatf("vec%0d", k));
        end

        // Beats without sop in IDLE are ignored; rd_end without wr_end does nothing.
        w0 = wr_cnt;
        beat(1'b1, 1'b0, 1'b0, 1'b0, 0);
        beat(1'b1, 1'b0, 1'b1, 1'b0, 0);
        rd_end = 1'b1;
        idle_cycles(2);
        rd_end = 1'b0;
        check("idle_ignored_writes", 32'(wr_cnt - w0), 32'd0);
        check("idle_wr_sel", 32'(wr_sel), 32'(exp_wsel));

        // sop mid-frame restarts at address 0.
        w0 = wr_cnt; e0 = err_cnt;
        send_frame(10, 1'b0, 1'b1);
        send_frame(FR, 1'b1, 1'b1);
        idle_cycles(3);
        check("restart_err", 32'(err_cnt - e0), 32'd1);
        check("restart_writes", 32'(wr_cnt - w0), 32'(10 + FR));
        check("restart_wr_end", 32'(wr_end), 32'd1);
        check("restart_queue", 32'(exp_q.size()), 32'd0);

        // Another frame while still in DONE is dropped.
        w0 = wr_cnt; e0 = err_cnt; d0 = drop_cnt;
        send_frame(FR, 1'b1, 1'b0);
        idle_cycles(3);
        check("drop_pulse", 32'(drop_cnt - d0), 32'd1);
        check("drop_writes", 32'(wr_cnt - w0), 32'd0);
        check("drop_err", 32'(err_cnt - e0), 32'd0);
        check("drop_wr_end", 32'(wr_end), 32'd1);
        swap("drop");

        // Asynchronous reset in the middle of a frame.
        e0 = err_cnt;
        for (int i = 0; i < 15; i++) beat(1'b1, i == 0, 1'b0, 1'b1, i);
        rst_n = 1'b0;
        #1;
        check("mid_rst_wr_en", 32'(wr_en), 32'd0);
        check("mid_rst_wr_addr", 32'(wr_addr), 32'd0);
        check("mid_rst_wr_data", 32'(wr_data), 32'd0);
        check("mid_rst_wr_end", 32'(wr_end), 32'd0);
        exp_q.delete();
        din_vld = 1'b0; din_sop = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        send_frame(FR, 1'b1, 1'b1);
        idle_cycles(3);
        check("post_rst_wr_end", 32'(wr_end), 32'd1);
        check("post_rst_err", 32'(err_cnt - e0), 32'd0);
        check("post_rst_queue", 32'(exp_q.size()), 32'd0);
        swap("post_rst");

        // One full-size 320x200 frame on the default-parameter instance.
        for (int i = 0; i < FULL_PIX; i++) begin
            logic [15:0] a;
            a = 16'(i);
            f_din = a[0] ^ a[7];
            f_vld = 1'b1;
            f_sop = (i == 0);
            f_eop = (i == FULL_PIX - 1);
            step();
        end
        f_vld = 1'b0; f_sop = 1'b0; f_eop = 1'b0;
        check("full_t1_wr_end", 32'(f_wr_end), 32'd0);
        check("full_t1_last_addr", 32'(f_wr_addr), 32'(FULL_PIX - 1));
        step();
        check("full_t2_wr_end", 32'(f_wr_end), 32'd1);
        step();
        check("full_writes", 32'(f_wr_cnt), 32'(FULL_PIX));
        check("full_bad_writes", 32'(f_bad), 32'd0);
        check("full_err", 32'(f_err_cnt), 32'd0);
        check("full_hold_wr_end", 32'(f_wr_end), 32'd1);
        check("full_wr_sel", 32'(f_wr_sel), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
